// File: rtl/debounce_fsm.sv
// debounce_fsm: synchronises a raw button level, samples it on tick strobes and
// accepts a new level only after it has held for STABLE_TICKS consecutive ticks.
// Produces a registered debounced level plus one-clock rise/fall strobes.
module debounce_fsm #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_in,
    output logic db_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b10,
        WAIT_LO = 2'b11
    } state_t;

    // Count value reached on the tick just before the final accepting tick.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_level_q, db_level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    assign btn_s = sync2_q;

    // Two-flop synchroniser bringing the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LOW;
            cnt_q      <= '0;
            db_level_q <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            db_level_q <= db_level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    // Next-state logic: a bounce back to the old level wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW: begin
                if (btn_s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!btn_s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!btn_s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (btn_s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        // The debounced level follows the state being entered, so it changes on
        // the same edge as the HIGH/LOW entry.
        db_level_d = (state_d == HIGH) || (state_d == WAIT_LO);
    end

    assign db_level   = db_level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed stimulus for debounce_fsm with tick every 10 clk.
// Expected strobes (cycle and direction) are queued when the button is driven
// and popped when the DUT emits a strobe.
module tb_debounce_fsm;

    localparam int ST = 4;
    localparam int CW = 3;
    localparam int TP = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic btn_in = 1'b0;
    logic db_level;
    logic rise_pulse;
    logic fall_pulse;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   c;
        logic r;
    } exp_t;
    exp_t exp_q[$];

    debounce_fsm #(.STABLE_TICKS(ST), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .btn_in     (btn_in),
        .db_level   (db_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    // Advance one clock; tick is high at posedges whose index is a multiple of TP.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick = ((cyc + 1) % TP == 0);
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // k-th tick posedge strictly after cycle start.
    function automatic int nth_tick(input int start, input int k);
        int t = start;
        for (int i = 0; i < k; i++) t = (t / TP + 1) * TP;
        return t;
    endfunction

    // Button driven just after posedge n reaches the FSM at posedge n+3 (WAIT
    // entry); acceptance happens on the ST-th tick after that entry.
    function automatic int accept_cyc(input int n);
        return nth_tick(n + 3, ST);
    endfunction

    task automatic expect_pulse(input logic r);
        exp_t e;
        e.c = accept_cyc(cyc);
        e.r = r;
        exp_q.push_back(e);
    endtask

    task automatic accept_check(input string tag, input logic lvl);
        int t;
        t = exp_q[$].c;
        wait_until(t - 1);
        chk({tag, "_level_before"}, 32'(db_level), 32'(!lvl));
        step();
        chk({tag, "_level_after"}, 32'(db_level), 32'(lvl));
        steps(3);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_db_level"}, 32'(db_level), 32'd0);
        chk({tag, "_rise"}, 32'(rise_pulse), 32'd0);
        chk({tag, "_fall"}, 32'(fall_pulse), 32'd0);
    endtask

    // Strobe monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rise_pulse || fall_pulse) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_pulse cyc %0d rise %0b fall %0b expected none",
                       cyc, rise_pulse, fall_pulse);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                assert (cyc === e.c && rise_pulse === e.r && fall_pulse === !e.r) else begin
                    errors++;
                    $error("FAIL pulse observed cyc %0d rise %0b fall %0b expected cyc %0d rise %0b fall %0b",
                           cyc, rise_pulse, fall_pulse, e.c, e.r, !e.r);
                end
            end
        end
    end

    initial begin
        int n;
        int t;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk_outputs_zero("reset");
        steps(3);
        reset = 1'b0;

        // 1: idle low, ticks ignored in LOW
        for (int i = 0; i < 10; i++) begin
            steps(20);
            chk("idle_low", 32'(db_level), 32'd0);
        end

        // 2: clean press
        btn_in = 1'b1;
        expect_pulse(1'b1);
        accept_check("press", 1'b1);

        // 5: clean release
        btn_in = 1'b0;
        expect_pulse(1'b0);
        accept_check("release", 1'b0);

        // 3: bounce during WAIT_HI restarts counting
        btn_in = 1'b1;
        steps(25);
        btn_in = 1'b0;
        steps(3);
        btn_in = 1'b1;
        chk("bounce_still_low", 32'(db_level), 32'd0);
        expect_pulse(1'b1);
        accept_check("bounce_press", 1'b1);

        // 4: return to 1 on the same cycle as the accepting tick in WAIT_LO
        n = cyc;
        btn_in = 1'b0;
        t = accept_cyc(n);
        wait_until(t - 3);
        btn_in = 1'b1;
        wait_until(t + 5);
        chk("bounce_priority_high", 32'(db_level), 32'd1);
        steps(40);
        chk("bounce_priority_hold", 32'(db_level), 32'd1);
        chk("bounce_priority_pending", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset from HIGH, button held high through release
        reset = 1'b1;
        #1;
        chk_outputs_zero("reset_from_high");
        steps(3);
        reset = 1'b0;
        expect_pulse(1'b1);
        accept_check("held_through_reset", 1'b1);

        // 6: reset in WAIT_HI with cnt=2 discards the partial count
        btn_in = 1'b0;
        expect_pulse(1'b0);
        accept_check("release2", 1'b0);
        n = cyc;
        btn_in = 1'b1;
        wait_until(nth_tick(n + 3, 2) + 1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("reset_in_wait_hi");
        steps(2);
        reset = 1'b0;
        expect_pulse(1'b1);
        accept_check("after_reset_press", 1'b1);

        steps(5);
        chk("final_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
